// File: rtl/icap_arbiter.sv
// ---------------------------------------------------------------------------
// icap_arbiter
//
// Owns the single ICAPE2 port and shares it, one transaction at a time,
// between a partial-bitstream stream port and a configuration-register read
// port. The read port runs an internally generated command sequence:
// sync, read header, read, desync. All data headed to the ICAP, and all
// readback data coming from it, is bit-reversed within each byte.
//
// Ports
//   CLK100       in   clock, 100MHz
//   SYS_RST_N    in   asynchronous active-low reset
//   S_REQ        in   stream request, level, held until S_LAST is accepted
//   S_D          in   stream word, configuration byte order
//   S_VALID      in   S_D valid
//   S_LAST       in   final word of the stream transaction
//   S_BP         out  1 = stream word not accepted this cycle
//   S_GNT        out  stream owns the ICAP
//   S_TMO        out  one-cycle pulse when an idle stream grant is revoked
//   R_REQ        in   register read request, level, held until R_ACK
//   R_ADDR       in   type-1 register address, latched at grant
//   R_DATA       out  readback value, bit order restored
//   R_ACK        out  one-cycle pulse, R_DATA valid
//   ICAP_CSIB    out  ICAPE2 CSIB
//   ICAP_RDWRB   out  ICAPE2 RDWRB, 0 = write
//   ICAP_I       out  ICAPE2 I, bits reversed within each byte
//   ICAP_O       in   ICAPE2 O
//   BUSY         out  arbiter is not idle
// ---------------------------------------------------------------------------
module icap_arbiter #(
    parameter int unsigned READ_LAT   = 3,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF,
    parameter int unsigned SWITCH_GAP = 2
) (
    input  logic        CLK100,
    input  logic        SYS_RST_N,
    input  logic        S_REQ,
    input  logic [31:0] S_D,
    input  logic        S_VALID,
    input  logic        S_LAST,
    output logic        S_BP,
    output logic        S_GNT,
    output logic        S_TMO,
    input  logic        R_REQ,
    input  logic [4:0]  R_ADDR,
    output logic [31:0] R_DATA,
    output logic        R_ACK,
    output logic        ICAP_CSIB,
    output logic        ICAP_RDWRB,
    output logic [31:0] ICAP_I,
    input  logic [31:0] ICAP_O,
    output logic        BUSY
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_S_XFER   = 3'd1;
    localparam logic [2:0] ST_R_WR     = 3'd2;
    localparam logic [2:0] ST_R_SW1    = 3'd3;
    localparam logic [2:0] ST_R_RD     = 3'd4;
    localparam logic [2:0] ST_R_SW2    = 3'd5;
    localparam logic [2:0] ST_R_DESYNC = 3'd6;
    localparam logic [2:0] ST_RELEASE  = 3'd7;

    localparam logic [15:0] LP_WR_LAST  = 16'd5;
    localparam logic [15:0] LP_DS_LAST  = 16'd3;
    localparam logic [15:0] LP_GAP_LAST = 16'(SWITCH_GAP - 1);
    localparam logic [15:0] LP_RD_LAST  = 16'(READ_LAT);
    localparam logic [15:0] LP_TMO_LAST = TIMEOUT - 16'd1;

    // Reverse the bit order inside each byte, leaving byte order alone.
    function automatic logic [31:0] f_rev(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned i = 0; i < 8; i++) begin
                y[b*8 + i] = x[b*8 + 7 - i];
            end
        end
        return y;
    endfunction

    // Sync and read-header words, logical (unreversed) order.
    function automatic logic [31:0] f_rd_cmd(input logic [2:0] idx,
                                             input logic [4:0] addr);
        case (idx)
            3'd0:    return 32'hFFFF_FFFF;
            3'd1:    return 32'hAA99_5566;
            3'd3:    return 32'h2800_0001 | {14'd0, addr, 13'd0};
            default: return 32'h2000_0000;
        endcase
    endfunction

    // Desync words, logical order.
    function automatic logic [31:0] f_desync(input logic [1:0] idx);
        case (idx)
            2'd0:    return 32'h3000_8001;
            2'd1:    return 32'h0000_000D;
            default: return 32'h2000_0000;
        endcase
    endfunction

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_last_rd;     // 1 = read port was served last
    logic [4:0]  r_addr;
    logic        r_csib;
    logic        r_rdwrb;
    logic [31:0] r_icap_i;
    logic [31:0] r_rdata;
    logic        r_tmo;
    logic        r_cap;

    logic [2:0]  w_state_nx;
    logic [15:0] w_cnt_nx;
    logic        w_last_rd_nx;
    logic        w_grant_rd;
    logic        w_csib_nx;
    logic        w_rdwrb_nx;
    logic [31:0] w_word_nx;
    logic        w_tmo_nx;
    logic        w_cap_nx;

    // Next-state and next-pin decode. ICAP pins are registered, so every pin
    // value computed here reaches the ICAP one cycle after the state that
    // produced it.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + 16'd1;
        w_last_rd_nx = r_last_rd;
        w_grant_rd   = 1'b0;
        w_csib_nx    = 1'b1;
        w_rdwrb_nx   = 1'b0;
        w_word_nx    = '0;
        w_tmo_nx     = 1'b0;
        w_cap_nx     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                // Stream wins when alone or when the read port went last.
                if (S_REQ && (!R_REQ || r_last_rd)) begin
                    w_state_nx   = ST_S_XFER;
                    w_last_rd_nx = 1'b0;
                end else if (R_REQ) begin
                    w_state_nx   = ST_R_WR;
                    w_last_rd_nx = 1'b1;
                    w_grant_rd   = 1'b1;
                end
            end

            ST_S_XFER: begin
                if (S_VALID) begin
                    w_csib_nx = 1'b0;
                    w_word_nx = S_D;
                    w_cnt_nx  = '0;
                    if (S_LAST) begin
                        w_state_nx = ST_RELEASE;
                    end
                end else if (r_cnt == LP_TMO_LAST) begin
                    w_state_nx = ST_RELEASE;
                    w_tmo_nx   = 1'b1;
                    w_cnt_nx   = '0;
                end
            end

            ST_R_WR: begin
                w_csib_nx = 1'b0;
                w_word_nx = f_rd_cmd(r_cnt[2:0], r_addr);
                if (r_cnt == LP_WR_LAST) begin
                    w_state_nx = ST_R_SW1;
                    w_cnt_nx   = '0;
                end
            end

            ST_R_SW1: begin
                w_rdwrb_nx = 1'b1;
                if (r_cnt == LP_GAP_LAST) begin
                    w_state_nx = ST_R_RD;
                    w_cnt_nx   = '0;
                end
            end

            ST_R_RD: begin
                w_csib_nx  = 1'b0;
                w_rdwrb_nx = 1'b1;
                if (r_cnt == LP_RD_LAST) begin
                    // The last read-enabled pin cycle is the next one, so the
                    // capture strobe is delayed by a cycle to line up with it.
                    w_state_nx = ST_R_SW2;
                    w_cnt_nx   = '0;
                    w_cap_nx   = 1'b1;
                end
            end

            ST_R_SW2: begin
                if (r_cnt == LP_GAP_LAST) begin
                    w_state_nx = ST_R_DESYNC;
                    w_cnt_nx   = '0;
                end
            end

            ST_R_DESYNC: begin
                w_csib_nx = 1'b0;
                w_word_nx = f_desync(r_cnt[1:0]);
                if (r_cnt == LP_DS_LAST) begin
                    w_state_nx = ST_RELEASE;
                    w_cnt_nx   = '0;
                end
            end

            ST_RELEASE: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK100 or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last_rd <= 1'b1;
            r_addr    <= '0;
            r_csib    <= 1'b1;
            r_rdwrb   <= 1'b0;
            r_icap_i  <= '0;
            r_rdata   <= '0;
            r_tmo     <= 1'b0;
            r_cap     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_last_rd <= w_last_rd_nx;
            r_csib    <= w_csib_nx;
            r_rdwrb   <= w_rdwrb_nx;
            r_tmo     <= w_tmo_nx;
            r_cap     <= w_cap_nx;
            if (w_grant_rd) begin
                r_addr <= R_ADDR;
            end
            // I holds its last value while deselected.
            if (!w_csib_nx) begin
                r_icap_i <= f_rev(w_word_nx);
            end
            if (r_cap) begin
                r_rdata <= f_rev(ICAP_O);
            end
        end
    end

    assign S_GNT      = (r_state == ST_S_XFER);
    assign S_BP       = (r_state != ST_S_XFER);
    assign S_TMO      = r_tmo;
    assign BUSY       = (r_state != ST_IDLE);
    // RELEASE after a read grant is the only RELEASE with r_last_rd set.
    assign R_ACK      = (r_state == ST_RELEASE) && r_last_rd;
    assign R_DATA     = r_rdata;
    assign ICAP_CSIB  = r_csib;
    assign ICAP_RDWRB = r_rdwrb;
    assign ICAP_I     = r_icap_i;

endmodule

// File: tb/tb_icap_arbiter.sv
module tb_icap_arbiter;

    localparam int READ_LAT = 3;

    logic        CLK100 = 1'b0;
    logic        SYS_RST_N;
    logic        S_REQ;
    logic [31:0] S_D;
    logic        S_VALID;
    logic        S_LAST;
    logic        S_BP;
    logic        S_GNT;
    logic        S_TMO;
    logic        R_REQ;
    logic [4:0]  R_ADDR;
    logic [31:0] R_DATA;
    logic        R_ACK;
    logic        ICAP_CSIB;
    logic        ICAP_RDWRB;
    logic [31:0] ICAP_I;
    logic [31:0] ICAP_O = 32'hDEAD_BEEF;
    logic        BUSY;

    icap_arbiter #(
        .READ_LAT  (3),
        .TIMEOUT   (16'd16),
        .SWITCH_GAP(2)
    ) dut (
        .CLK100    (CLK100),
        .SYS_RST_N (SYS_RST_N),
        .S_REQ     (S_REQ),
        .S_D       (S_D),
        .S_VALID   (S_VALID),
        .S_LAST    (S_LAST),
        .S_BP      (S_BP),
        .S_GNT     (S_GNT),
        .S_TMO     (S_TMO),
        .R_REQ     (R_REQ),
        .R_ADDR    (R_ADDR),
        .R_DATA    (R_DATA),
        .R_ACK     (R_ACK),
        .ICAP_CSIB (ICAP_CSIB),
        .ICAP_RDWRB(ICAP_RDWRB),
        .ICAP_I    (ICAP_I),
        .ICAP_O    (ICAP_O),
        .BUSY      (BUSY)
    );

    always #5 CLK100 = ~CLK100;

    int tests = 0;
    int fails = 0;

    logic [31:0] wlog[$];
    int          csib_low   = 0;
    int          rdwr_viol  = 0;
    int          tmo_pulses = 0;
    int          rdcnt      = 0;
    logic        prev_rdwrb = 1'b0;
    logic [31:0] rd_val     = '0;

    function automatic logic [31:0] brev(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                r[b*8 + i] = x[b*8 + 7 - i];
        return r;
    endfunction

    // ICAP pin monitor and readback model: O carries rd_val (bit-reversed)
    // only on the READ_LAT-th cycle after the first read-enabled cycle.
    always @(negedge CLK100) begin
        if (!ICAP_CSIB) begin
            csib_low++;
            if (ICAP_RDWRB != prev_rdwrb) rdwr_viol++;
        end
        if (!ICAP_CSIB && !ICAP_RDWRB) wlog.push_back(ICAP_I);
        if (!ICAP_CSIB && ICAP_RDWRB && SYS_RST_N) rdcnt++;
        else rdcnt = 0;
        ICAP_O = (rdcnt == READ_LAT + 1) ? brev(rd_val) : 32'hDEAD_BEEF;
        if (S_TMO) tmo_pulses++;
        prev_rdwrb = ICAP_RDWRB;
    end

    task automatic step();
        @(negedge CLK100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (!R_ACK && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_ack_seen"}, 32'(R_ACK), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({ICAP_CSIB, ICAP_RDWRB, S_GNT, S_BP, R_ACK, S_TMO, BUSY}),
            32'(7'b1001000));
        chk({tag, "_icap_i"}, ICAP_I, 32'h0);
        chk({tag, "_rdata"}, R_DATA, 32'h0);
    endtask

    logic [31:0] exp_rd[10] = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h2801_8001,
                                32'h2000_0000, 32'h2000_0000, 32'h3000_8001, 32'h0000_000D,
                                32'h2000_0000, 32'h2000_0000};
    logic [31:0] s_words[4] = '{32'h0102_0304, 32'h0506_0708, 32'h1122_3344, 32'hA5C3_F00F};
    logic [31:0] s_rev[4]   = '{32'h8040_C020, 32'hA060_E010, 32'h8844_CC22, 32'hA5C3_0FF0};

    initial begin
        int base;
        int c0;
        int t0;
        int n;
        logic [5:0] obs;

        SYS_RST_N = 1'b0;
        S_REQ = 1'b0; S_VALID = 1'b0; S_LAST = 1'b0; S_D = '0;
        R_REQ = 1'b0; R_ADDR = '0;
        step(); step();
        chk_reset_outputs("reset");
        SYS_RST_N = 1'b1;
        step();

        // Simultaneous requests after reset: stream first, then read.
        S_REQ = 1'b1; R_REQ = 1'b1; R_ADDR = 5'h0C; rd_val = 32'h0365_1093;
        S_VALID = 1'b1; S_D = 32'h1122_3344; S_LAST = 1'b1;
        step();
        chk("both_stream_first", 32'({S_GNT, BUSY}), 32'(2'b11));
        step();
        S_REQ = 1'b0; S_VALID = 1'b0; S_LAST = 1'b0;
        chk("b_word", ICAP_I, 32'h8844_CC22);
        chk("b_release", 32'({S_GNT, S_BP, BUSY, ICAP_CSIB}), 32'(4'b0110));
        step();
        chk("b_idle", 32'({BUSY, ICAP_CSIB}), 32'(2'b01));
        step();
        chk("b_read_gnt", 32'({S_GNT, BUSY}), 32'(2'b01));
        R_ADDR = 5'h1F;
        base = wlog.size();
        wait_ack("rd1");
        chk("rd1_data", R_DATA, 32'h0365_1093);
        chk("rd1_nwords", 32'(wlog.size() - base), 32'd10);
        for (int i = 0; i < 10; i++)
            if (base + i < wlog.size())
                chk($sformatf("rd1_word%0d", i), brev(wlog[base + i]), exp_rd[i]);
        chk("rd1_rdwrb_rule", 32'(rdwr_viol), 32'd0);
        R_REQ = 1'b0;
        step();
        chk("rd1_ack_pulse", 32'(R_ACK), 32'd0);

        // Stream-only, four back-to-back words.
        S_REQ = 1'b1; S_VALID = 1'b1; S_D = s_words[0];
        step();
        chk("c_gnt", 32'({S_GNT, S_BP, BUSY}), 32'(3'b101));
        base = wlog.size();
        for (int i = 0; i < 4; i++) begin
            S_D = s_words[i]; S_LAST = (i == 3); S_VALID = 1'b1;
            step();
        end
        S_REQ = 1'b0; S_VALID = 1'b0; S_LAST = 1'b0;
        chk("c_release", 32'({S_GNT, S_BP, BUSY}), 32'(3'b011));
        step();
        chk("c_done", 32'({BUSY, ICAP_CSIB}), 32'(2'b01));
        chk("c_nwords", 32'(wlog.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (base + i < wlog.size())
                chk($sformatf("c_word%0d", i), wlog[base + i], s_rev[i]);

        // Gapped stream: words driven in cycles 0, 3, 4.
        S_REQ = 1'b1; S_VALID = 1'b0;
        step();
        chk("d_gnt", 32'(S_GNT), 32'd1);
        c0 = csib_low; t0 = tmo_pulses;
        obs = '0;
        for (int c = 0; c < 6; c++) begin
            S_VALID = (c == 0 || c == 3 || c == 4);
            S_LAST  = (c == 4);
            S_REQ   = (c < 5);
            S_D     = 32'h1000_0000 + 32'(c);
            step();
            obs[c] = ICAP_CSIB;
        end
        S_VALID = 1'b0; S_LAST = 1'b0;
        chk("d_csib_pattern", 32'(obs), 32'(6'b100110));
        chk("d_csib_low_cnt", 32'(csib_low - c0), 32'd3);
        chk("d_no_timeout", 32'(tmo_pulses - t0), 32'd0);
        step();
        chk("d_idle", 32'(BUSY), 32'd0);

        // Simultaneous requests with stream served last: read first.
        S_REQ = 1'b1; R_REQ = 1'b1; R_ADDR = 5'h02; rd_val = 32'h8001_7FFE;
        step();
        chk("e_read_first", 32'({S_GNT, BUSY}), 32'(2'b01));
        base = wlog.size();
        wait_ack("rd2");
        chk("rd2_data", R_DATA, 32'h8001_7FFE);
        if (base + 3 < wlog.size())
            chk("rd2_header", brev(wlog[base + 3]), 32'h2800_4001);
        R_REQ = 1'b0;
        step();
        step();
        chk("e_stream_next", 32'(S_GNT), 32'd1);

        // Stream idles with a read pending: forced release after 16 cycles.
        R_REQ = 1'b1; R_ADDR = 5'h10; rd_val = 32'hCAFE_1234;
        c0 = csib_low;
        n = 1;
        while (S_GNT && n < 100) begin
            step();
            if (S_GNT) n++;
        end
        chk("tmo_len", 32'(n), 32'd16);
        chk("tmo_pulse", 32'(S_TMO), 32'd1);
        chk("tmo_csib_high", 32'(csib_low - c0), 32'd0);
        S_REQ = 1'b0;
        step();
        chk("tmo_pulse_end", 32'({S_TMO, BUSY}), 32'(2'b00));
        step();
        chk("tmo_read_gnt", 32'({S_GNT, BUSY}), 32'(2'b01));

        // Reset while reading, then a fresh read.
        n = 0;
        while (!(ICAP_CSIB == 1'b0 && ICAP_RDWRB == 1'b1) && n < 50) begin
            step();
            n++;
        end
        chk("rrd_reached", 32'({ICAP_CSIB, ICAP_RDWRB}), 32'(2'b01));
        #2 SYS_RST_N = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        step();
        SYS_RST_N = 1'b1;
        base = wlog.size();
        wait_ack("rd3");
        chk("rd3_data", R_DATA, 32'hCAFE_1234);
        if (base + 3 < wlog.size())
            chk("rd3_header", brev(wlog[base + 3]), 32'h2802_0001);
        chk("rd3_rdwrb_rule", 32'(rdwr_viol), 32'd0);
        R_REQ = 1'b0;
        step();
        step();
        chk("final_idle", 32'({BUSY, ICAP_CSIB}), 32'(2'b01));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
